// File: rtl/seq_driver.sv
`default_nettype none
// ============================================================================
// Module   : seq_driver
// Brief    : Emits a fixed 12-step unlock vector sequence toward a lock detector.
// Revision : 1.0
// ============================================================================
module seq_driver #(
  parameter int unsigned GAP      = 0,
  parameter logic [3:0]  IDLE_VEC = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  input  logic       abort,
  output logic       i1,
  output logic       i2,
  output logic       i3,
  output logic       i4,
  output logic [3:0] step,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] GAP_CNT  = 4'(GAP);
  localparam logic [3:0] LAST_STEP = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       advance;

  // Vector order is {i1,i2,i3,i4}.
  function automatic logic [3:0] step_vec(input logic [3:0] n);
    case (n)
      4'd1:    step_vec = 4'b0010;
      4'd2:    step_vec = 4'b1001;
      4'd3:    step_vec = 4'b1000;
      4'd4:    step_vec = 4'b0010;
      4'd5:    step_vec = 4'b0100;
      4'd6:    step_vec = 4'b1000;
      4'd7:    step_vec = 4'b0001;
      4'd8:    step_vec = 4'b0000;
      4'd9:    step_vec = 4'b0001;
      4'd10:   step_vec = 4'b0010;
      4'd11:   step_vec = 4'b1000;
      default: step_vec = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      gap_q   <= 4'd0;
      vec_q   <= IDLE_VEC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    gap_d   = gap_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    advance = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      step_d  = 4'd0;
      gap_d   = 4'd0;
      vec_d   = IDLE_VEC;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SEND;
            step_d  = 4'd1;
            vec_d   = step_vec(4'd1);
            gap_d   = GAP_CNT;
            busy_d  = 1'b1;
          end
        end
        S_SEND: begin
          if (!hold) begin
            if (GAP_CNT != 4'd0) state_d = S_GAP;
            else                 advance = 1'b1;
          end
        end
        S_GAP: begin
          // Counter enters at GAP and advances on the edge where it reads 1.
          if (!hold) begin
            if (gap_q <= 4'd1) advance = 1'b1;
            else               gap_d   = gap_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (advance) begin
        if (step_q == LAST_STEP) begin
          state_d = S_DONE;
          step_d  = 4'd0;
          gap_d   = 4'd0;
          vec_d   = IDLE_VEC;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_SEND;
          step_d  = step_q + 4'd1;
          vec_d   = step_vec(step_q + 4'd1);
          gap_d   = GAP_CNT;
        end
      end
    end
  end

  assign {i1, i2, i3, i4} = vec_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_driver
// Brief    : Directed self-checking bench for seq_driver (GAP=0 and GAP=2).
// Revision : 1.0
// ============================================================================
module tb_seq_driver;

  logic clk, reset, start, hold, abort;
  logic d0_i1, d0_i2, d0_i3, d0_i4, d0_busy, d0_done;
  logic d2_i1, d2_i2, d2_i3, d2_i4, d2_busy, d2_done;
  logic [3:0] d0_step, d2_step, d0_vec, d2_vec;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] tab [1:12];
  logic [3:0] seen [1:12];

  seq_driver #(.GAP(0), .IDLE_VEC(4'b0000)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .i1(d0_i1), .i2(d0_i2), .i3(d0_i3), .i4(d0_i4),
    .step(d0_step), .busy(d0_busy), .done(d0_done)
  );

  seq_driver #(.GAP(2), .IDLE_VEC(4'b0000)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .i1(d2_i1), .i2(d2_i2), .i3(d2_i3), .i4(d2_i4),
    .step(d2_step), .busy(d2_busy), .done(d2_done)
  );

  assign d0_vec = {d0_i1, d0_i2, d0_i3, d0_i4};
  assign d2_vec = {d2_i1, d2_i2, d2_i3, d2_i4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lock detector advance condition for state s, v = {i1,i2,i3,i4}.
  function automatic bit det_cond(input int s, input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    case (s)
      0:  det_cond = c;
      1:  det_cond = a & d;
      2:  det_cond = !c;
      3:  det_cond = !a & c;
      4:  det_cond = b & !a & !d;
      5:  det_cond = a;
      6:  det_cond = d;
      7:  det_cond = !d & !c;
      8:  det_cond = d & !a;
      9:  det_cond = !b & c;
      10: det_cond = a & !d;
      11: det_cond = !c;
      default: det_cond = 1'b0;
    endcase
  endfunction

  task automatic run_seq0(input string tag);
    int s;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("%s step%0d", tag, k), d0_step, k);
      check($sformatf("%s vec%0d", tag, k), d0_vec, tab[k]);
      check($sformatf("%s busy%0d", tag, k), d0_busy, 1);
      check($sformatf("%s nodone%0d", tag, k), d0_done, 0);
      seen[k] = d0_vec;
      tick();
    end
    check({tag, " done"}, d0_done, 1);
    check({tag, " done_busy"}, d0_busy, 0);
    check({tag, " done_step"}, d0_step, 0);
    check({tag, " done_vec"}, d0_vec, 4'b0000);
    tick();
    check({tag, " done_pulse_end"}, d0_done, 0);
    s = 0;
    for (int k = 1; k <= 12; k++) s = det_cond(s, seen[k]) ? s + 1 : 0;
    check({tag, " detector_final"}, s, 12);
  endtask

  initial begin
    int s;
    bit saw_done;
    tab[1] = 4'b0010; tab[2]  = 4'b1001; tab[3]  = 4'b1000; tab[4]  = 4'b0010;
    tab[5] = 4'b0100; tab[6]  = 4'b1000; tab[7]  = 4'b0001; tab[8]  = 4'b0000;
    tab[9] = 4'b0001; tab[10] = 4'b0010; tab[11] = 4'b1000; tab[12] = 4'b0000;
    reset = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;

    // Reset is checked before any clock edge has occurred.
    #3;
    check("rst step", d0_step, 0);
    check("rst vec", d0_vec, 4'b0000);
    check("rst busy", d0_busy, 0);
    check("rst done", d0_done, 0);
    check("rst d2 step", d2_step, 0);
    tick();
    reset = 1'b1;

    run_seq0("g0");

    s = 0;
    for (int k = 1; k <= 12; k++) s = det_cond(s, (k == 8) ? 4'b0010 : seen[k]) ? s + 1 : 0;
    check("detector_forced8", s, 0);

    // start together with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort busy", d0_busy, 0);
    check("start_abort step", d0_step, 0);

    // GAP=2: each vector held 3 cycles; start pulses while busy ignored
    reset = 1'b0; tick(); reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      for (int h = 0; h < 3; h++) begin
        check($sformatf("gap2 step%0d.%0d", k, h), d2_step, k);
        check($sformatf("gap2 vec%0d.%0d", k, h), d2_vec, tab[k]);
        check($sformatf("gap2 busy%0d.%0d", k, h), d2_busy, 1);
        start = (k == 4 && h == 1) || (k == 12 && h == 2);
        tick();
      end
    end
    start = 1'b0;
    check("gap2 done", d2_done, 1);
    check("gap2 done_busy", d2_busy, 0);
    check("gap2 done_step", d2_step, 0);
    tick();
    check("gap2 after_done", d2_done, 0);
    check("gap2 not_queued", d2_busy, 0);
    check("gap2 idle_step", d2_step, 0);

    // hold 4 cycles at step 5 with GAP=0
    reset = 1'b0; tick(); reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("hold step%0d", k), d0_step, k);
      check($sformatf("hold vec%0d", k), d0_vec, tab[k]);
      if (k == 5) begin
        hold = 1'b1;
        for (int h = 0; h < 4; h++) begin
          tick();
          check($sformatf("hold frz step%0d", h), d0_step, 5);
          check($sformatf("hold frz vec%0d", h), d0_vec, 4'b0100);
          check($sformatf("hold frz busy%0d", h), d0_busy, 1);
        end
        hold = 1'b0;
      end
      tick();
    end
    check("hold done", d0_done, 1);
    check("hold done_step", d0_step, 0);

    // abort at step 7
    reset = 1'b0; tick(); reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("abort at7 step", d0_step, 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort step", d0_step, 0);
    check("abort vec", d0_vec, 4'b0000);
    check("abort busy", d0_busy, 0);
    saw_done = 1'b0;
    for (int c = 0; c < 14; c++) begin
      saw_done |= d0_done;
      tick();
    end
    check("abort no_done", saw_done, 0);
    run_seq0("postabort");

    // async reset between edges at step 9
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("rst9 at9 step", d0_step, 9);
    #2;
    reset = 1'b0;
    #1;
    check("rst9 step", d0_step, 0);
    check("rst9 vec", d0_vec, 4'b0000);
    check("rst9 busy", d0_busy, 0);
    tick();
    reset = 1'b1;
    tick();
    check("rst9 waits", d0_busy, 0);
    run_seq0("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
